// File: rtl/riscv_mt_pkg.sv
// Shared types and helpers for the 4-thread pipeline writeback path.
package riscv_mt_pkg;

    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned WB_DATA_W   = 64;

    // Full writeback entry as seen by the register file.
    typedef struct packed {
        logic [WB_DATA_W-1:0]   data;
        logic [REG_ADDR_W-1:0]  rd;
        logic [NUM_THREADS-1:0] thread;
    } wb_entry_t;

    // Destination tag carried alongside buffered data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0]  rd;
        logic [NUM_THREADS-1:0] thread;
    } wb_tag_t;

    // True when exactly one thread bit is set.
    function automatic logic is_onehot4(input logic [NUM_THREADS-1:0] t);
        return (t != '0) && ((t & (t - NUM_THREADS'(1))) == '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Memory-result buffer: synchronous FIFO with occupancy-based full/empty
// and an OR of the thread tags of every valid entry.
module wb_fifo
    import riscv_mt_pkg::*;
#(
    parameter int unsigned D_WIDTH    = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [D_WIDTH-1:0]     push_data,
    input  wb_tag_t                push_tag,
    output logic [D_WIDTH-1:0]     head_data,
    output wb_tag_t                head_tag,
    output logic                   full,
    output logic                   empty,
    output logic [NUM_THREADS-1:0] pending
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [D_WIDTH-1:0] data_q [FIFO_DEPTH];
    wb_tag_t            tag_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   offs;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign head_data = data_q[rd_ptr];
    assign head_tag  = tag_q[rd_ptr];

    // Entry storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= push_data;
            tag_q[wr_ptr]  <= push_tag;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot i is valid when its distance from the read pointer is below count.
    always_comb begin
        pending = '0;
        offs    = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if ({1'b0, offs} < count) pending = pending | tag_q[i].thread;
        end
    end

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: ALU results always win the register-file port,
// memory results queue in wb_fifo and drain in ALU-free cycles; a
// starvation counter asks upstream to freeze so the queue can drain.
module wb_arb
    import riscv_mt_pkg::*;
#(
    parameter int unsigned D_WIDTH      = 64,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    input  logic [D_WIDTH-1:0]     alu_data,
    input  logic [REG_ADDR_W-1:0]  alu_rd,
    input  logic [NUM_THREADS-1:0] alu_thread,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [D_WIDTH-1:0]     mem_data,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic [NUM_THREADS-1:0] mem_thread,
    output logic [D_WIDTH-1:0]     data_WB,
    output logic                   ctrl_WB,
    output logic [REG_ADDR_W-1:0]  reg_wraddr,
    output logic [NUM_THREADS-1:0] thread_sel_WB,
    output logic [NUM_THREADS-1:0] wb_pending,
    output logic                   stall_req,
    output logic                   wb_err
);

    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [D_WIDTH-1:0]     head_data;
    wb_tag_t                head_tag;
    logic                   push_c;
    logic                   pop_c;
    logic                   sel_valid_c;
    logic [D_WIDTH-1:0]     sel_data_c;
    logic [REG_ADDR_W-1:0]  sel_rd_c;
    logic [NUM_THREADS-1:0] sel_thread_c;
    logic                   sel_onehot_c;
    logic [SCNT_W-1:0]      starve_cnt;

    assign push_c    = mem_valid & ~fifo_full;
    assign pop_c     = ~alu_valid & ~fifo_empty;
    assign mem_ready = ~fifo_full;

    wb_fifo #(
        .D_WIDTH    (D_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (mem_data),
        .push_tag  ('{rd: mem_rd, thread: mem_thread}),
        .head_data (head_data),
        .head_tag  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .pending   (wb_pending)
    );

    // Source select: ALU first, then FIFO head, else nothing.
    always_comb begin
        sel_valid_c  = 1'b0;
        sel_data_c   = '0;
        sel_rd_c     = '0;
        sel_thread_c = '0;
        if (alu_valid) begin
            sel_valid_c  = 1'b1;
            sel_data_c   = alu_data;
            sel_rd_c     = alu_rd;
            sel_thread_c = alu_thread;
        end else if (!fifo_empty) begin
            sel_valid_c  = 1'b1;
            sel_data_c   = head_data;
            sel_rd_c     = head_tag.rd;
            sel_thread_c = head_tag.thread;
        end
        sel_onehot_c = is_onehot4(sel_thread_c);
    end

    // Register-file write port and sticky thread-field error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_WB       <= '0;
            ctrl_WB       <= 1'b0;
            reg_wraddr    <= '0;
            thread_sel_WB <= '0;
            wb_err        <= 1'b0;
        end else begin
            data_WB       <= sel_data_c;
            reg_wraddr    <= sel_rd_c;
            thread_sel_WB <= sel_thread_c;
            ctrl_WB       <= sel_valid_c & (sel_rd_c != '0) & sel_onehot_c;
            if (sel_valid_c && !sel_onehot_c) wb_err <= 1'b1;
        end
    end

    // Count cycles the FIFO head loses to the ALU; freeze request follows a cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (fifo_empty || pop_c)
                starve_cnt <= '0;
            else if (starve_cnt != SCNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SCNT_W'(1);
            stall_req <= (starve_cnt == SCNT_W'(STARVE_LIMIT));
        end
    end

endmodule

// File: tb/tb_wb_arb.sv
// Scoreboard bench for wb_arb: a queue-based reference model predicts the
// outputs after each edge; a monitor compares them on the falling edge.
module tb_wb_arb;
    import riscv_mt_pkg::*;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [DW-1:0] alu_data = '0;
    logic [4:0]    alu_rd = '0;
    logic [3:0]    alu_thread = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [DW-1:0] mem_data = '0;
    logic [4:0]    mem_rd = '0;
    logic [3:0]    mem_thread = '0;
    logic [DW-1:0] data_WB;
    logic          ctrl_WB;
    logic [4:0]    reg_wraddr;
    logic [3:0]    thread_sel_WB;
    logic [3:0]    wb_pending;
    logic          stall_req;
    logic          wb_err;

    wb_arb #(.D_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_data(alu_data), .alu_rd(alu_rd), .alu_thread(alu_thread),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_rd(mem_rd), .mem_thread(mem_thread),
        .data_WB(data_WB), .ctrl_WB(ctrl_WB), .reg_wraddr(reg_wraddr),
        .thread_sel_WB(thread_sel_WB), .wb_pending(wb_pending),
        .stall_req(stall_req), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic [3:0]    thr;
    } ent_t;

    typedef struct {
        logic          sel_v;
        logic          ctrl;
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic [3:0]    thr;
        logic          mem_ready;
        logic [3:0]    pending;
        logic          stall;
        logic          err;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   starve = 0;
    logic err_m = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory results wait in a queue; ALU wins each cycle.
    initial forever begin
        @(posedge clk);
        if (reset_n) begin
            exp_t e;
            ent_t s;
            bit   pop;
            bit   push;
            int   ones;
            pop  = !alu_valid && (mq.size() != 0);
            push = mem_valid && (mq.size() < DEPTH);
            e.sel_v = alu_valid || pop;
            if (alu_valid) begin
                s.data = alu_data; s.rd = alu_rd; s.thr = alu_thread;
            end else if (pop) begin
                s = mq[0];
            end else begin
                s.data = '0; s.rd = '0; s.thr = '0;
            end
            ones   = $countones(s.thr);
            e.ctrl = e.sel_v && (s.rd != 0) && (ones == 1);
            if (e.sel_v && ones != 1) err_m = 1'b1;
            e.err   = err_m;
            e.data  = s.data;
            e.rd    = s.rd;
            e.thr   = s.thr;
            e.stall = (starve == LIMIT);
            if (mq.size() == 0 || pop) starve = 0;
            else if (starve < LIMIT) starve++;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{mem_data, mem_rd, mem_thread});
            e.mem_ready = (mq.size() < DEPTH);
            e.pending = '0;
            foreach (mq[i]) e.pending = e.pending | mq[i].thr;
            sb.push_back(e);
        end
    end

    // Monitor: compare predicted outputs half a cycle after each edge.
    initial forever begin
        @(negedge clk);
        if (reset_n && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ctrl_WB", DW'(ctrl_WB), DW'(e.ctrl));
            if (e.sel_v) begin
                chk("data_WB", data_WB, e.data);
                chk("reg_wraddr", DW'(reg_wraddr), DW'(e.rd));
                chk("thread_sel_WB", DW'(thread_sel_WB), DW'(e.thr));
            end
            chk("mem_ready", DW'(mem_ready), DW'(e.mem_ready));
            chk("wb_pending", DW'(wb_pending), DW'(e.pending));
            chk("stall_req", DW'(stall_req), DW'(e.stall));
            chk("wb_err", DW'(wb_err), DW'(e.err));
        end
    end

    // One cycle of stimulus; upstream honours stall_req by holding off the ALU.
    task automatic drive(input logic av, input logic [DW-1:0] ad, input logic [4:0] ard,
                         input logic [3:0] at, input logic mv, input logic [DW-1:0] md,
                         input logic [4:0] mrd, input logic [3:0] mt);
        @(negedge clk);
        #1;
        alu_valid  = av && !stall_req;
        alu_data   = ad;
        alu_rd     = ard;
        alu_thread = at;
        mem_valid  = mv;
        mem_data   = md;
        mem_rd     = mrd;
        mem_thread = mt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, '0, 0, '0, '0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl_WB"}, DW'(ctrl_WB), '0);
        chk({tag, "_data_WB"}, data_WB, '0);
        chk({tag, "_reg_wraddr"}, DW'(reg_wraddr), '0);
        chk({tag, "_thread_sel_WB"}, DW'(thread_sel_WB), '0);
        chk({tag, "_wb_pending"}, DW'(wb_pending), '0);
        chk({tag, "_stall_req"}, DW'(stall_req), '0);
        chk({tag, "_wb_err"}, DW'(wb_err), '0);
        chk({tag, "_mem_ready"}, DW'(mem_ready), DW'(1));
    endtask

    function automatic logic [3:0] rand_thr();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 15));
        return 4'(1) << $urandom_range(0, 3);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        #1 reset_n = 1'b1;

        // ALU alone.
        drive(1, 64'h1234, 5'd5, 4'b0001, 0, '0, '0, '0);
        idle(2);
        // Memory alone.
        drive(0, '0, '0, '0, 1, 64'hBEEF, 5'd7, 4'b0100);
        idle(3);
        // Fill with the ALU busy, then drain.
        for (int i = 0; i < 5; i++)
            drive(1, DW'(100 + i), 5'd1, 4'b0010, 1, DW'(200 + i), 5'(10 + i), 4'(1) << (i % 4));
        drive(0, '0, '0, '0, 0, '0, '0, '0);
        chk("fill_full_mem_ready", DW'(mem_ready), '0);
        idle(6);
        // Starvation: one entry, ALU kept busy until the freeze request.
        drive(1, 64'h55, 5'd3, 4'b1000, 1, 64'hCAFE, 5'd9, 4'b0001);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1, DW'(i), 5'd4, 4'b0100, 0, '0, '0, '0);
            if (stall_req) got = 1;
        end
        chk("stall_req_rise", DW'(got), DW'(1));
        idle(4);
        // x0 write is silent; bad thread is sticky.
        drive(1, 64'h77, 5'd0, 4'b0001, 0, '0, '0, '0);
        idle(2);
        drive(0, '0, '0, '0, 1, 64'hBAD, 5'd6, 4'b0011);
        idle(5);
        chk("err_sticky", DW'(wb_err), DW'(1));
        // Reset with three entries queued.
        for (int i = 0; i < 3; i++)
            drive(1, DW'(i), 5'd2, 4'b0001, 1, DW'(300 + i), 5'(20 + i), 4'b0010);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        mq.delete();
        sb.delete();
        starve = 0;
        err_m = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #1 reset_n = 1'b1;
        idle(5);
        // Randomised traffic.
        for (int i = 0; i < 1500; i++)
            drive(($urandom_range(0, 99) < 50), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  rand_thr(), ($urandom_range(0, 99) < 60), {$urandom, $urandom},
                  5'($urandom_range(0, 31)), rand_thr());
        idle(12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arb.md
# wb_arb

Writeback arbiter for the 4-thread pipeline. It merges the fixed-latency ALU result stream with the variable-latency memory/accelerator result stream into the single register-file write port. It drives data_WB, ctrl_WB, reg_wraddr and thread_sel_WB of the dual-bank thread register file directly from registers. Memory results are buffered in a small FIFO. The ALU always wins, and a starvation counter requests a pipeline freeze so buffered results drain.

## Interface

Parameters:
- D_WIDTH, 64, result/register data width
- FIFO_DEPTH, 4, memory-result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a FIFO head may wait before stall_req

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_data  in  D_WIDTH  ALU result
- alu_rd  in  5  destination register
- alu_thread  in  4  one-hot thread of ALU result
- mem_valid  in  1  memory/accelerator result offered
- mem_ready  out  1  FIFO can accept; transfer when mem_valid & mem_ready at clk edge
- mem_data  in  D_WIDTH  memory/accelerator result
- mem_rd  in  5  destination register
- mem_thread  in  4  one-hot thread
- data_WB  out  D_WIDTH  write data to register file
- ctrl_WB  out  1  write enable
- reg_wraddr  out  5  write address
- thread_sel_WB  out  4  one-hot thread of the write
- wb_pending  out  4  bit t high while any FIFO entry belongs to thread t
- stall_req  out  1  request upstream to suppress alu_valid
- wb_err  out  1  sticky: a non-one-hot thread field was accepted

## Operation

- Reset: all outputs 0, except mem_ready, which is 1. Also: FIFO empty, starve counter 0, wb_err 0.
- Each cycle, select one source.
  - If alu_valid is 1, select the ALU.
  - Otherwise, if the FIFO is non-empty, select the FIFO head and pop it.
  - Otherwise, select nothing.
- Output registers load the selected entry.
- ctrl_WB = 1 only if the selected entry has rd ≠ 0 and a one-hot thread. Otherwise ctrl_WB = 0. data_WB, reg_wraddr and thread_sel_WB still load the entry.
- An x0 write is consumed silently, with no error.
- A non-one-hot thread (zero or multi-hot) consumes the entry, drives ctrl_WB = 0, and sets wb_err. Only reset clears wb_err.
- FIFO push: mem_valid & mem_ready.
  - mem_ready = !full, computed from the registered occupancy.
  - When full, no push is accepted, even if a pop happens the same cycle.
- Push and pop in the same cycle on a non-empty FIFO leave occupancy unchanged.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy is log2(FIFO_DEPTH)+1 bits.
- wb_pending: OR of the thread fields of all valid entries. It is combinational from the FIFO state and updates the cycle after a push or pop.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the ALU is selected.
  - Resets to 0 on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_req: registered, 1 when the counter equals STARVE_LIMIT.
  - Upstream must hold alu_valid = 0 in every cycle stall_req = 1.
  - alu_valid = 1 while stall_req = 1 is a protocol violation. The ALU still wins in that case.
- Asynchronous reset mid-operation discards FIFO contents and any in-flight output.

## Timing

- ALU path latency is 1.
  - alu_valid is sampled at edge N; ctrl_WB/data_WB are valid after edge N, for one cycle.
- Memory path minimum latency is 2.
  - Handshake at edge N puts the entry in the FIFO.
  - With no ALU in cycle N+1, the write appears after edge N+1.
- Throughput: one register write per cycle maximum.
- stall_req timing:
  - It rises one cycle after the counter reaches STARVE_LIMIT.
  - The head pops in the first cycle with alu_valid = 0.
  - stall_req falls after the following edge.
- No combinational path from any input to any output except wb_pending (from state only) and mem_ready (from state only).

## Structure

- Shared package riscv_mt_pkg:
  - NUM_THREADS = 4
  - REG_ADDR_W = 5
  - wb_entry_t {data, rd, thread}
  - function is_onehot4
- Sub-module wb_fifo holds the synchronous FIFO: storage, pointers, occupancy, full/empty, pending OR.
- wb_arb holds select logic, output registers, starve counter and error flag.

## Test plan

- ALU alone:
  - alu_valid with data 0x1234, rd 5, thread 0001 → after the next edge, ctrl_WB = 1, reg_wraddr = 5, thread_sel_WB = 0001, data_WB = 0x1234, for one cycle.
- Memory alone:
  - Push rd 7, thread 0100, data 0xBEEF at edge N → write visible after edge N+1.
  - wb_pending = 0100 from N to N+1.
- Fill and drain:
  - With alu_valid held 1, push 5 memory results → mem_ready low after the 4th.
  - Release the ALU → 4 writes in FIFO order on consecutive cycles, then mem_ready = 1.
- Starvation:
  - One FIFO entry, alu_valid = 1 for 8 cycles → stall_req = 1.
  - Bench drops alu_valid → entry written, stall_req = 0 the next cycle.
- x0 and bad thread:
  - ALU rd 0 → ctrl_WB = 0 and wb_err stays 0.
  - Memory thread 0011 → ctrl_WB = 0, wb_err = 1, held until reset.
- Reset mid-operation:
  - Assert reset_n low with 3 entries queued → all outputs 0 and mem_ready = 1 immediately.
  - No writes after release.
